truth_table_probe: RTL
======================

// Module: truth_table_probe
// PURPOSE
//   Sequential characteriser for 3-input logic gates such as the 0x88 case block.
//   It sweeps {in1,in2,in3} through 000..111 and samples the gate output for each
//   input combination. From those samples it rebuilds the 8-bit truth-table code
//   and compares it with an expected code. It sits on the bench or
//   self-test side of a gate and reads the function back from the gate output.
// PARAMETERS
//   SETTLE_CYCLES  4  cycles each input combination is held before sampling (>= SYNC_STAGES+1)
//   SAMPLES        3  samples per row, majority-voted; must be odd and >= 1
//   SYNC_STAGES    2  flops in the dut_out synchroniser; must be >= 1
// PORTS
//   clk          in   1  rising-edge clock
//   rst          in   1  asynchronous, active-high reset
//   start        in   1  1-cycle request to begin a sweep; honoured only in IDLE
//   abort        in   1  terminates a sweep in progress; done does not assert
//   expected     in   8  truth-table code to compare against; latched when start is accepted
//   dut_out      in   1  output of the gate under test; asynchronous
//   probe_in1    out  1  drives gate in1 (MSB of the row index)
//   probe_in2    out  1  drives gate in2
//   probe_in3    out  1  drives gate in3 (LSB of the row index)
//   busy         out  1  high from the cycle after start is accepted until DONE is left
//   done         out  1  1-cycle pulse; truth_table and match are valid in that cycle
//   truth_table  out  8  reconstructed code; bit (7-r) = voted output for row r
//   match        out  1  truth_table == latched expected; updated with done
// BEHAVIOUR
//   - Reset: state=IDLE, probes=000, busy=0, done=0, truth_table=8'h00, match=0.
//     The synchroniser flops and all counters clear.
//   - dut_out passes through SYNC_STAGES flops before it is used. It is never sampled raw.
//   - The FSM has five states: IDLE, SETTLE, SAMPLE, COMMIT, DONE.
//   - IDLE -> SETTLE when start=1. On that transition, row=0, the expected code is
//     latched, the shadow table is cleared, and busy=1 from the next cycle.
//   - SETTLE holds the probes at row for SETTLE_CYCLES cycles, then moves to SAMPLE.
//   - SAMPLE lasts SAMPLES cycles. Each cycle, the synced dut_out is added to a ones counter.
//   - COMMIT lasts 1 cycle. It writes shadow[7-row] = (ones > SAMPLES/2) and clears ones.
//     If row==7 the FSM goes to DONE; otherwise row increments and the FSM goes to SETTLE.
//   - DONE lasts 1 cycle. truth_table<=shadow, match<=(shadow==expected_q), done=1.
//     The FSM then returns to IDLE.
//   - probe_{in1,in2,in3} = row[2:0] in SETTLE, SAMPLE and COMMIT. Probes are 000 in IDLE and DONE.
//   - Latency: if start is accepted in cycle 0, done asserts in cycle
//     8*(SETTLE_CYCLES+SAMPLES+1)+1. With the defaults this is cycle 65.
//   - truth_table and match hold their values until the next DONE, so they stay
//     unchanged through a new sweep and through an abort.
//   - start while busy is ignored, and expected is not re-latched.
//   - abort has priority over start and over every state transition.
//     It returns the FSM to IDLE on the next edge with probes=000 and no done pulse.
//     truth_table and match keep their previous values.
//   - start and abort together in IDLE: abort wins, so no sweep begins.
//   - Reset mid-sweep: immediate return to reset values, including truth_table and match.
//   - The row counter is 3 bits. The FSM leaves to DONE at row 7, so the counter never wraps.
//   - Settle and sample counters are $clog2(max+1) bits. The ones counter is $clog2(SAMPLES+1) bits.
// TESTING
//   1. Gate model out=~in2&~in3, expected=8'h88, start -> done at cycle 65, truth_table=8'h88, match=1.
//   2. Same gate with expected=8'h89 -> truth_table=8'h88, match=0.
//   3. Gate 0x88 with dut_out forced inverted for 1 of the 3 sample cycles of row 000
//      -> majority vote gives truth_table=8'h88.
//   4. Pulse start again at cycle 10 of a sweep -> ignored; done is still at cycle 65
//      and expected keeps its first latched value.
//   5. Assert rst during row 3 -> probes=000, busy=0, truth_table=8'h00, no done pulse.
//   6. After a completed sweep (tt=8'h88), a new sweep aborted at row 5
//      -> FSM returns to IDLE, no done pulse, truth_table stays 8'h88.

Source files
------------

// File: rtl/truth_table_probe.sv
// ---------------------------------------------------------------------------
// truth_table_probe
//   Sequential characteriser for a 3-input combinational gate. It walks the
//   gate inputs {in1,in2,in3} through rows 000..111. Each row is held for a
//   settle window, and then the synchronised gate output is sampled several
//   times and majority-voted. The eight votes are assembled into an 8-bit
//   truth-table code, in which bit (7-row) holds the output for that row. The
//   code is compared against an expected code that is captured at start.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        1-cycle sweep request, accepted only when idle
//   abort        cancels a sweep in progress (no done pulse)
//   expected     reference truth-table code, captured when start is accepted
//   dut_out      gate output, asynchronous to clk
//   probe_in1    gate in1 (row bit 2)
//   probe_in2    gate in2 (row bit 1)
//   probe_in3    gate in3 (row bit 0)
//   busy         sweep in progress (any state other than IDLE)
//   done         1-cycle pulse, truth_table/match valid in that cycle
//   truth_table  reconstructed code, held until the next completed sweep
//   match        truth_table == captured expected code
// ---------------------------------------------------------------------------
module truth_table_probe #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       probe_in1,
    output logic       probe_in2,
    output logic       probe_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       match
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SAMPLE_W = $clog2(SAMPLES + 1);
    localparam int ONES_W   = $clog2(SAMPLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        COMMIT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                synced;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SAMPLE_W-1:0] sample_cnt;
    logic [ONES_W-1:0]   ones;
    logic [2:0]          row;
    logic [7:0]          shadow;
    logic [7:0]          shadow_next;
    logic [7:0]          expected_q;
    logic                settle_last;
    logic                sample_last;
    logic                vote;
    logic                probe_active;

    // Shift register synchroniser. The MSB is the only tap that the logic reads.
    // A shift form is used instead of a slice concatenation so that a single stage still works.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples its pre-edge value, whatever the order of the statements.
        if (rst) sync_q <= '0;
        else     sync_q <= (sync_q << 1) | SYNC_STAGES'(dut_out);
    end
    assign synced = sync_q[SYNC_STAGES-1];

    assign settle_last = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
    assign sample_last = (sample_cnt == SAMPLE_W'(SAMPLES - 1));
    assign vote        = (ones > ONES_W'(SAMPLES / 2));

    // This is the shadow table with the current row's vote merged in. COMMIT uses it both
    // to update the shadow table and, on the last row, to load truth_table directly. As a
    // result, the result is already valid in the DONE cycle.
    always_comb begin
        // NOTE: a default comes first so that every path assigns the signal
        // and no latch is inferred.
        shadow_next               = shadow;
        shadow_next[3'd7 - row]   = vote;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)       state_next = SETTLE;
            SETTLE:  if (settle_last) state_next = SAMPLE;
            SAMPLE:  if (sample_last) state_next = COMMIT;
            COMMIT:  state_next = (row == 3'd7) ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // abort overrides start and every other transition
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the 8-bit shadow table is a plain register rather than a RAM.
        // It is therefore reset together with everything else.
        if (rst) begin
            settle_cnt  <= '0;
            sample_cnt  <= '0;
            ones        <= '0;
            row         <= '0;
            shadow      <= '0;
            expected_q  <= '0;
            truth_table <= '0;
            match       <= 1'b0;
        end else if (abort) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
            ones       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        row        <= '0;
                        expected_q <= expected;
                        shadow     <= '0;
                        settle_cnt <= '0;
                        sample_cnt <= '0;
                        ones       <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_last) settle_cnt <= '0;
                    else             settle_cnt <= settle_cnt + 1'b1;
                end
                SAMPLE: begin
                    ones <= ones + ONES_W'(synced);
                    if (sample_last) sample_cnt <= '0;
                    else             sample_cnt <= sample_cnt + 1'b1;
                end
                COMMIT: begin
                    shadow <= shadow_next;
                    ones   <= '0;
                    if (row == 3'd7) begin
                        truth_table <= shadow_next;
                        match       <= (shadow_next == expected_q);
                    end else begin
                        row <= row + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign probe_active = (state == SETTLE) || (state == SAMPLE) || (state == COMMIT);
    assign {probe_in1, probe_in2, probe_in3} = probe_active ? row : 3'b000;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
